// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//
// Memory-access stage of a 5-stage RV32I pipeline. Holds the byte-addressed
// data memory (2^ADDR_WIDTH bytes, little-endian, built as 32-bit words) and
// the MEM/WB pipeline register feeding the writeback mux.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-low reset (clears MEM/WB outputs)
//   en              advance enable; 0 holds the outputs and blocks stores
//   clr             flush; MEM/WB register loads a bubble (stores still commit)
//   alu_res_in      ALU result / memory byte address
//   w_data_in       store data (rs2)
//   rd_in           destination register index
//   pc_plus4_in     PC+4 for JAL/JALR writeback
//   funct3_in       access size and sign
//   reg_write_in    register-file write enable
//   result_src_in   writeback select: 00 ALU, 01 load, 10 PC+4
//   mem_write_in    store enable
//   alu_res_out     registered alu_res_in
//   read_data_out   registered, lane-selected and extended load data
//   rd_out          registered rd
//   pc_plus4_out    registered pc_plus4
//   reg_write_out   registered reg_write, dropped on a misaligned load
//   result_src_out  registered result_src
//   misaligned_out  registered misaligned-access flag
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int REG_WIDTH  = 5,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] alu_res_in,
    input  logic [DATA_WIDTH-1:0] w_data_in,
    input  logic [REG_WIDTH-1:0]  rd_in,
    input  logic [PC_WIDTH-1:0]   pc_plus4_in,
    input  logic [2:0]            funct3_in,
    input  logic                  reg_write_in,
    input  logic [1:0]            result_src_in,
    input  logic                  mem_write_in,
    output logic [DATA_WIDTH-1:0] alu_res_out,
    output logic [DATA_WIDTH-1:0] read_data_out,
    output logic [REG_WIDTH-1:0]  rd_out,
    output logic [PC_WIDTH-1:0]   pc_plus4_out,
    output logic                  reg_write_out,
    output logic [1:0]            result_src_out,
    output logic                  misaligned_out
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 2);

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } size_e;

    // ---------------------------------------------------------------- decode
    logic [ADDR_WIDTH-3:0] word_idx;
    logic [1:0]            lane;
    size_e                 acc_size;
    logic                  zero_ext;
    logic                  is_load;
    logic                  misaligned;
    logic                  mis_load;

    // Upper address bits are intentionally ignored, so addresses alias.
    assign word_idx = alu_res_in[ADDR_WIDTH-1:2];
    assign lane     = alu_res_in[1:0];
    assign is_load  = (result_src_in == 2'b01);

    always_comb begin
        acc_size = SIZE_WORD;
        zero_ext = 1'b0;
        case (funct3_in)
            3'b000: acc_size = SIZE_BYTE;
            3'b001: acc_size = SIZE_HALF;
            3'b100: begin
                acc_size = SIZE_BYTE;
                zero_ext = 1'b1;
            end
            3'b101: begin
                acc_size = SIZE_HALF;
                zero_ext = 1'b1;
            end
            default: acc_size = SIZE_WORD;
        endcase
    end

    // Alignment only matters for real memory accesses; ALU/JAL traffic with
    // arbitrary low address bits must not raise the flag.
    always_comb begin
        misaligned = 1'b0;
        if (is_load || mem_write_in) begin
            case (acc_size)
                SIZE_HALF: misaligned = lane[0];
                SIZE_WORD: misaligned = (lane != 2'b00);
                default:   misaligned = 1'b0;
            endcase
        end
    end

    assign mis_load = misaligned & is_load;

    // ---------------------------------------------------------------- store
    logic [3:0]            byte_en;
    logic [DATA_WIDTH-1:0] store_word;
    logic                  store_fire;

    // Store data is replicated across lanes so the byte enables alone pick
    // which bytes land in the word.
    always_comb begin
        byte_en    = 4'b0000;
        store_word = w_data_in;
        case (acc_size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << lane;
                store_word = {4{w_data_in[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                store_word = {2{w_data_in[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_word = w_data_in;
            end
        endcase
    end

    // clr is deliberately absent: a flush squashes the writeback, not the store.
    assign store_fire = rst & en & mem_write_in & ~misaligned;

    logic [DATA_WIDTH-1:0] mem_array [WORDS];

    always_ff @(posedge clk) begin
        if (store_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem_array[word_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    // ---------------------------------------------------------------- load
    logic [DATA_WIDTH-1:0] mem_word;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign mem_word = mem_array[word_idx];

    always_comb begin
        lane_byte = mem_word[7:0];
        case (lane)
            2'd0: lane_byte = mem_word[7:0];
            2'd1: lane_byte = mem_word[15:8];
            2'd2: lane_byte = mem_word[23:16];
            2'd3: lane_byte = mem_word[31:24];
            default: lane_byte = mem_word[7:0];
        endcase
        lane_half = lane[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_ext = mem_word;
        case (acc_size)
            SIZE_BYTE: load_ext = zero_ext ? {24'b0, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_ext = zero_ext ? {16'b0, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default:   load_ext = mem_word;
        endcase
    end

    // ---------------------------------------------------------------- MEM/WB
    logic [DATA_WIDTH-1:0] alu_res_d,    alu_res_q;
    logic [DATA_WIDTH-1:0] read_data_d,  read_data_q;
    logic [REG_WIDTH-1:0]  rd_d,         rd_q;
    logic [PC_WIDTH-1:0]   pc_plus4_d,   pc_plus4_q;
    logic                  reg_write_d,  reg_write_q;
    logic [1:0]            result_src_d, result_src_q;
    logic                  misaligned_d, misaligned_q;

    always_comb begin
        alu_res_d    = alu_res_q;
        read_data_d  = read_data_q;
        rd_d         = rd_q;
        pc_plus4_d   = pc_plus4_q;
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        misaligned_d = misaligned_q;
        if (clr) begin
            alu_res_d    = '0;
            read_data_d  = '0;
            rd_d         = '0;
            pc_plus4_d   = '0;
            reg_write_d  = 1'b0;
            result_src_d = 2'b00;
            misaligned_d = 1'b0;
        end else if (en) begin
            alu_res_d    = alu_res_in;
            read_data_d  = mis_load ? '0 : load_ext;
            rd_d         = rd_in;
            pc_plus4_d   = pc_plus4_in;
            reg_write_d  = reg_write_in & ~mis_load;
            result_src_d = result_src_in;
            misaligned_d = misaligned;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_res_q    <= '0;
            read_data_q  <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            misaligned_q <= 1'b0;
        end else begin
            alu_res_q    <= alu_res_d;
            read_data_q  <= read_data_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign alu_res_out    = alu_res_q;
    assign read_data_out  = read_data_q;
    assign rd_out         = rd_q;
    assign pc_plus4_out   = pc_plus4_q;
    assign reg_write_out  = reg_write_q;
    assign result_src_out = result_src_q;
    assign misaligned_out = misaligned_q;

endmodule
